// File: rtl/blackjack_round_ctrl_pkg.sv
// Shared types and constants for the blackjack round sequencer.
package blackjack_round_ctrl_pkg;

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StDealP1  = 4'd1,
        StDealD1  = 4'd2,
        StDealP2  = 4'd3,
        StDealD2  = 4'd4,
        StPTurn   = 4'd5,
        StPDraw   = 4'd6,
        StDCheck  = 4'd7,
        StDDraw   = 4'd8,
        StResolve = 4'd9,
        StDone    = 4'd10
    } state_t;

    localparam logic [1:0] RES_NONE   = 2'd0;
    localparam logic [1:0] RES_PLAYER = 2'd1;
    localparam logic [1:0] RES_DEALER = 2'd2;
    localparam logic [1:0] RES_PUSH   = 2'd3;

    localparam logic [4:0] BUST_LIMIT = 5'd21;
    localparam logic [4:0] ACE_BONUS  = 5'd10;
    localparam logic [3:0] CARD_MIN   = 4'd1;
    localparam logic [3:0] CARD_MAX   = 4'd10;

    function automatic logic is_draw_state(input state_t s);
        return (s == StDealP1) || (s == StDealD1) || (s == StDealP2) || (s == StDealD2) ||
               (s == StPDraw) || (s == StDDraw);
    endfunction

    function automatic logic card_legal(input logic [3:0] v);
        return (v >= CARD_MIN) && (v <= CARD_MAX);
    endfunction

endpackage

// File: rtl/blackjack_round_ctrl_hand_accum.sv
// One hand: hard total, ace flag, and the derived effective total / bust flag.
module hand_accum
    import blackjack_round_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       add,
    input  logic [3:0] value,
    output logic [4:0] hard,
    output logic [4:0] eff,
    output logic       bust
);

    logic [4:0] hard_q;
    logic       has_ace_q;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            hard_q    <= 5'd0;
            has_ace_q <= 1'b0;
        end else if (add) begin
            hard_q <= hard_q + {1'b0, value};
            if (value == CARD_MIN) begin
                has_ace_q <= 1'b1;
            end
        end
    end

    // An ace counts as 11 only while that keeps the hand at or under the limit.
    assign hard = hard_q;
    assign eff  = (has_ace_q && (hard_q <= (BUST_LIMIT - ACE_BONUS))) ? hard_q + ACE_BONUS
                                                                      : hard_q;
    assign bust = hard_q > BUST_LIMIT;

endmodule

// File: rtl/blackjack_round_ctrl.sv
// Round sequencer: deal order, player turn, dealer auto-draw and result resolution.
module blackjack_round_ctrl
    import blackjack_round_ctrl_pkg::*;
#(
    parameter int unsigned DEALER_STAND = 17
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       hit,
    input  logic       stand,
    input  logic       card_valid,
    input  logic [3:0] card_in,
    output logic       draw_req,
    output logic [4:0] player_total,
    output logic [4:0] dealer_total,
    output logic [1:0] result,
    output logic       done,
    output logic [3:0] state
);

    state_t     state_q;
    state_t     state_d;
    logic       accept;
    logic       round_start;
    logic       p_add;
    logic       d_add;
    logic [4:0] p_hard;
    logic [4:0] p_eff;
    logic       p_bust;
    logic [4:0] d_hard;
    logic [4:0] d_eff;
    logic       d_bust;
    logic [4:0] p_hard_next;
    logic       d_stands;
    logic [1:0] res_calc;
    logic       unused_dealer_hard;

    assign accept      = draw_req && card_valid && card_legal(card_in);
    assign round_start = start && ((state_q == StIdle) || (state_q == StDone));
    assign p_add       = accept && ((state_q == StDealP1) || (state_q == StDealP2) ||
                                    (state_q == StPDraw));
    assign d_add       = accept && ((state_q == StDealD1) || (state_q == StDealD2) ||
                                    (state_q == StDDraw));
    assign p_hard_next = p_hard + {1'b0, card_in};
    assign d_stands    = 32'(d_eff) >= DEALER_STAND;

    assign unused_dealer_hard = ^d_hard;

    hand_accum u_player (
        .clock (clock),
        .reset (reset),
        .clear (round_start),
        .add   (p_add),
        .value (card_in),
        .hard  (p_hard),
        .eff   (p_eff),
        .bust  (p_bust)
    );

    hand_accum u_dealer (
        .clock (clock),
        .reset (reset),
        .clear (round_start),
        .add   (d_add),
        .value (card_in),
        .hard  (d_hard),
        .eff   (d_eff),
        .bust  (d_bust)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: if (round_start) state_d = StDealP1;
            StDealP1:       if (accept) state_d = StDealD1;
            StDealD1:       if (accept) state_d = StDealP2;
            StDealP2:       if (accept) state_d = StDealD2;
            StDealD2:       if (accept) state_d = StPTurn;
            StPTurn: begin
                // Stand takes priority when both buttons land in the same cycle.
                if (stand) begin
                    state_d = StDCheck;
                end else if (hit) begin
                    state_d = StPDraw;
                end
            end
            StPDraw: begin
                if (accept) begin
                    state_d = (p_hard_next <= BUST_LIMIT) ? StPTurn : StResolve;
                end
            end
            StDCheck:  state_d = d_stands ? StResolve : StDDraw;
            StDDraw:   if (accept) state_d = StDCheck;
            StResolve: state_d = StDone;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        res_calc = RES_PUSH;
        if (p_bust) begin
            res_calc = RES_DEALER;
        end else if (d_bust) begin
            res_calc = RES_PLAYER;
        end else if (p_eff > d_eff) begin
            res_calc = RES_PLAYER;
        end else if (d_eff > p_eff) begin
            res_calc = RES_DEALER;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            draw_req <= 1'b0;
            result   <= RES_NONE;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            draw_req <= is_draw_state(state_d);
            done     <= (state_d == StDone);
            if (round_start) begin
                result <= RES_NONE;
            end else if (state_q == StResolve) begin
                result <= res_calc;
            end
        end
    end

    assign player_total = p_eff;
    assign dealer_total = d_eff;
    assign state        = state_q;

endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// Self-checking bench: directed table, corner sequences and randomized rounds vs a card-game model.
module tb_blackjack_round_ctrl;

    localparam int S_IDLE   = 0;
    localparam int S_DEALP1 = 1;
    localparam int S_DEALD1 = 2;
    localparam int S_PTURN  = 5;
    localparam int S_PDRAW  = 6;
    localparam int S_DCHECK = 7;
    localparam int S_DONE   = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       hit;
    logic       stand;
    logic       card_valid;
    logic [3:0] card_in;
    logic       draw_req;
    logic [4:0] player_total;
    logic [4:0] dealer_total;
    logic [1:0] result;
    logic       done;
    logic [3:0] state;

    always #5 clock = ~clock;

    blackjack_round_ctrl #(.DEALER_STAND(17)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .hit          (hit),
        .stand        (stand),
        .card_valid   (card_valid),
        .card_in      (card_in),
        .draw_req     (draw_req),
        .player_total (player_total),
        .dealer_total (dealer_total),
        .result       (result),
        .done         (done),
        .state        (state)
    );

    // Card i of the deck lives in nibble i of c.
    typedef struct packed {
        logic [7:0][3:0] c;
        logic [3:0]      hits;
        logic [4:0]      ep;
        logic [4:0]      ed;
        logic [1:0]      eres;
        logic [3:0]      eused;
    } vec_t;

    vec_t vecs[9];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   card_q[32];
    int   hits_left;
    bit   saw_dcheck;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic int eff_of(input int sum, input bit ace);
        return (ace && (sum + 10 <= 21)) ? sum + 10 : sum;
    endfunction

    function automatic vec_t mk(input logic [31:0] cards, input int hits, input int ep,
                                input int ed, input int eres, input int eused);
        vec_t v;
        v.c     = cards;
        v.hits  = 4'(hits);
        v.ep    = 5'(ep);
        v.ed    = 5'(ed);
        v.eres  = 2'(eres);
        v.eused = 4'(eused);
        return v;
    endfunction

    task automatic load_cards(input vec_t v);
        for (int i = 0; i < 32; i++) begin
            int c;
            c = (i < 8) ? int'(v.c[i]) : 0;
            card_q[i] = (c != 0) ? c : $urandom_range(1, 10);
        end
    endtask

    // Game rules at the level of hands: player hits below a threshold, dealer to 17.
    task automatic model_round(input int thr, output int hits, output int pe, output int de,
                               output int res, output int used);
        int ps;
        int ds;
        bit pa;
        bit da;
        int k;
        ps = card_q[0] + card_q[2];
        pa = (card_q[0] == 1) || (card_q[2] == 1);
        ds = card_q[1] + card_q[3];
        da = (card_q[1] == 1) || (card_q[3] == 1);
        k = 4;
        hits = 0;
        while (ps <= 21 && eff_of(ps, pa) < thr && k < 32) begin
            ps += card_q[k];
            pa |= (card_q[k] == 1);
            k++;
            hits++;
        end
        if (ps > 21) begin
            res = 2;
        end else begin
            while (eff_of(ds, da) < 17 && k < 32) begin
                ds += card_q[k];
                da |= (card_q[k] == 1);
                k++;
            end
            if (ds > 21) res = 1;
            else if (eff_of(ps, pa) > eff_of(ds, da)) res = 1;
            else if (eff_of(ds, da) > eff_of(ps, pa)) res = 2;
            else res = 3;
        end
        pe = eff_of(ps, pa);
        de = eff_of(ds, da);
        used = k;
    endtask

    task automatic run_round(input bit noisy, input int n_hits, output int cycles,
                             output int used);
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 0;
        used = 0;
        saw_dcheck = 1'b0;
        hits_left = n_hits;
        while (!done && cycles < 300) begin
            bit acc;
            int r;
            acc = 1'b0;
            card_valid = 1'b0;
            card_in = 4'd0;
            hit = 1'b0;
            stand = 1'b0;
            start = 1'b0;
            if (state == 4'(S_DCHECK)) saw_dcheck = 1'b1;
            if (draw_req) begin
                if (noisy && $urandom_range(0, 3) == 0) begin
                    card_valid = 1'($urandom_range(0, 1));
                    r = $urandom_range(10, 15);
                    card_in = (r == 10) ? 4'd0 : 4'(r);
                end else begin
                    card_valid = 1'b1;
                    card_in = 4'(card_q[(used < 32) ? used : 31]);
                    acc = 1'b1;
                end
                if (noisy) begin
                    hit = 1'($urandom_range(0, 1));
                    stand = 1'($urandom_range(0, 1));
                    start = 1'($urandom_range(0, 1));
                end
            end else begin
                if (noisy) begin
                    card_valid = 1'($urandom_range(0, 1));
                    card_in = 4'($urandom_range(1, 10));
                end
                if (state == 4'(S_PTURN)) begin
                    if (hits_left > 0) begin
                        hit = 1'b1;
                        hits_left--;
                    end else begin
                        stand = 1'b1;
                        if (noisy) hit = 1'($urandom_range(0, 1));
                    end
                end
            end
            tick();
            cycles++;
            if (acc) used++;
        end
        card_valid = 1'b0;
        card_in = 4'd0;
        hit = 1'b0;
        stand = 1'b0;
        start = 1'b0;
    endtask

    task automatic check_round(input string tag, input int ep, input int ed, input int eres,
                               input int used_exp, input int used);
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_state"}, int'(state), S_DONE);
        check({tag, "_draw_req"}, int'(draw_req), 0);
        check({tag, "_player_total"}, int'(player_total), ep);
        check({tag, "_dealer_total"}, int'(dealer_total), ed);
        check({tag, "_result"}, int'(result), eres);
        check({tag, "_cards_used"}, used, used_exp);
    endtask

    task automatic give_card(input int v);
        int w;
        w = 0;
        while (!draw_req && w < 20) begin
            tick();
            w++;
        end
        card_valid = 1'b1;
        card_in = 4'(v);
        tick();
        card_valid = 1'b0;
        card_in = 4'd0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int cycles;
        int used;
        int hits;
        int pe;
        int de;
        int res;
        int mused;
        int thr;

        vecs[0] = mk(32'h0000A97A, 0, 19, 17, 1, 4);
        vecs[1] = mk(32'h0008265A, 1, 24, 7, 2, 5);
        vecs[2] = mk(32'h000A76A1, 1, 17, 17, 3, 5);
        vecs[3] = mk(32'h0043685A, 0, 18, 18, 3, 6);
        vecs[4] = mk(32'h000A69AA, 0, 19, 26, 1, 5);
        vecs[5] = mk(32'h0000A7AA, 0, 17, 20, 2, 4);
        vecs[6] = mk(32'h00006919, 0, 18, 17, 1, 4);
        vecs[7] = mk(32'h005A5A11, 0, 21, 21, 3, 6);
        vecs[8] = mk(32'h000685AA, 1, 21, 18, 1, 5);

        reset = 1'b1;
        start = 1'b0;
        hit = 1'b0;
        stand = 1'b0;
        card_valid = 1'b0;
        card_in = 4'd0;
        @(negedge clock);
        tick();
        tick();
        check("reset_state", int'(state), S_IDLE);
        check("reset_draw_req", int'(draw_req), 0);
        check("reset_player_total", int'(player_total), 0);
        check("reset_dealer_total", int'(dealer_total), 0);
        check("reset_result", int'(result), 0);
        check("reset_done", int'(done), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            load_cards(vecs[i]);
            run_round(1'b0, int'(vecs[i].hits), cycles, used);
            check_round($sformatf("vec%0d", i), int'(vecs[i].ep), int'(vecs[i].ed),
                        int'(vecs[i].eres), int'(vecs[i].eused), used);
            if (i == 0) check("min_round_cycles", cycles, 7);
            if (vecs[i].ep > 21) check($sformatf("vec%0d_no_dcheck", i), int'(saw_dcheck), 0);
        end

        // Handshake stress on the first deal card.
        pulse_start();
        check("hs_enter_deal", int'(state), S_DEALP1);
        for (int k = 0; k < 5; k++) begin
            card_valid = 1'b0;
            card_in = 4'd7;
            tick();
            check($sformatf("hs_invalid%0d_state", k), int'(state), S_DEALP1);
            check($sformatf("hs_invalid%0d_req", k), int'(draw_req), 1);
        end
        card_valid = 1'b1;
        card_in = 4'd0;
        tick();
        check("hs_zero_state", int'(state), S_DEALP1);
        check("hs_zero_req", int'(draw_req), 1);
        card_in = 4'd12;
        tick();
        check("hs_twelve_state", int'(state), S_DEALP1);
        check("hs_twelve_req", int'(draw_req), 1);
        card_in = 4'd4;
        tick();
        card_valid = 1'b0;
        check("hs_four_state", int'(state), S_DEALD1);
        check("hs_deal_to_deal_req", int'(draw_req), 1);
        give_card(10);
        give_card(6);
        give_card(10);
        check("hs_pturn_state", int'(state), S_PTURN);
        check("hs_pturn_req", int'(draw_req), 0);
        check("hs_player_total", int'(player_total), 10);
        check("hs_dealer_total", int'(dealer_total), 20);

        // Reset in the middle of a pending player draw.
        hit = 1'b1;
        tick();
        hit = 1'b0;
        check("rst_pdraw_state", int'(state), S_PDRAW);
        check("rst_pdraw_req", int'(draw_req), 1);
        card_valid = 1'b1;
        card_in = 4'd5;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        card_valid = 1'b0;
        check("rst_state", int'(state), S_IDLE);
        check("rst_draw_req", int'(draw_req), 0);
        check("rst_player_total", int'(player_total), 0);
        check("rst_dealer_total", int'(dealer_total), 0);
        load_cards(vecs[0]);
        run_round(1'b0, 0, cycles, used);
        check_round("post_rst", 19, 17, 1, 4, used);

        // Soft ace that hardens without busting.
        pulse_start();
        give_card(1);
        give_card(10);
        give_card(6);
        give_card(7);
        check("soft_pturn_state", int'(state), S_PTURN);
        check("soft_player_total", int'(player_total), 17);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        give_card(10);
        check("soft_hit_state", int'(state), S_PTURN);
        check("soft_hit_total", int'(player_total), 17);
        stand = 1'b1;
        tick();
        stand = 1'b0;
        for (int w = 0; w < 40 && !done; w++) tick();
        check("soft_done", int'(done), 1);
        check("soft_result", int'(result), 3);
        check("soft_dealer_total", int'(dealer_total), 17);

        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 32; k++) begin
                int c;
                c = $urandom_range(1, 13);
                card_q[k] = (c > 10) ? 10 : c;
            end
            thr = $urandom_range(12, 22);
            model_round(thr, hits, pe, de, res, mused);
            run_round(1'(i % 2), hits, cycles, used);
            check_round($sformatf("rnd%0d", i), pe, de, res, mused, used);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
